// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude-compare sequencer: walks two WIDTH-bit operands MSB-pair
// first through one shared external 2-bit comparator slice and stops at the
// first unequal pair.
module serial_mag_compare_ctrl #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SUW   = $clog2(WIDTH / 2 + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic [SUW-1:0]   slices_used,
    output logic             sl_a1,
    output logic             sl_a0,
    output logic             sl_b1,
    output logic             sl_b0,
    input  logic             sl_gt,
    input  logic             sl_eq,
    input  logic             sl_lt
);

    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    // Operand width must split into whole bit-pairs.
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             busy_d, done_d;
    logic             gt_d, eq_d, lt_d;
    logic [SUW-1:0]   su_d;
    logic [1:0]       pair_a, pair_b;

    // Current bit-pair of each operand, selected by idx.
    always_comb begin
        pair_a = 2'(a_q >> {idx_q, 1'b0});
        pair_b = 2'(b_q >> {idx_q, 1'b0});
    end

    // Slice inputs are only driven while a comparison is in flight.
    always_comb begin
        sl_a1 = 1'b0;
        sl_a0 = 1'b0;
        sl_b1 = 1'b0;
        sl_b0 = 1'b0;
        if (state_q == CMP) begin
            sl_a1 = pair_a[1];
            sl_a0 = pair_a[0];
            sl_b1 = pair_b[1];
            sl_b0 = pair_b[0];
        end
    end

    // Next-state and next-output logic; slice result priority is gt > lt > eq.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        busy_d  = busy;
        done_d  = 1'b0;
        gt_d    = a_gt_b;
        eq_d    = a_eq_b;
        lt_d    = a_lt_b;
        su_d    = slices_used;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    idx_d   = IDXW'(N - 1);
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    su_d    = '0;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (sl_gt || sl_lt || idx_q == '0) begin
                    // Decision reached: either an unequal pair or the last pair.
                    if (sl_gt) begin
                        gt_d = 1'b1;
                    end else if (sl_lt) begin
                        lt_d = 1'b1;
                    end else begin
                        eq_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    su_d    = SUW'(N) - SUW'(idx_q);
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            a_gt_b      <= 1'b0;
            a_eq_b      <= 1'b0;
            a_lt_b      <= 1'b0;
            slices_used <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            busy        <= busy_d;
            done        <= done_d;
            a_gt_b      <= gt_d;
            a_eq_b      <= eq_d;
            a_lt_b      <= lt_d;
            slices_used <= su_d;
        end
    end

endmodule
